fp_cmp_unit: RTL

- Two-stage pipelined single-precision compare/select unit for the FP execute path.
- Handles FEQ.S, FLT.S, FLE.S, FMIN.S, FMAX.S and FCLASS.S.
- Stage 1 classifies both operands into the 10-bit one-hot class mask; stage 2 consumes the masks to produce the integer/FP result and the invalid (NV) flag.
- Sits between FP register-file read and writeback, with a valid/ready handshake on both sides.

---
 rtl/fp_pkg.sv | 38 +++
 rtl/fp_class_mask.sv | 37 +++
 rtl/fp_cmp_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the FP compare/select path: op codes, class-mask
// bit positions and IEEE-754 single-precision field positions.
package fp_pkg;

    typedef enum logic [2:0] {
        OP_FEQ    = 3'd0,
        OP_FLT    = 3'd1,
        OP_FLE    = 3'd2,
        OP_FMIN   = 3'd3,
        OP_FMAX   = 3'd4,
        OP_FCLASS = 3'd5
    } fp_op_e;

    localparam int unsigned CLS_W    = 10;
    localparam int unsigned CLS_NINF = 0;
    localparam int unsigned CLS_NNRM = 1;
    localparam int unsigned CLS_NSUB = 2;
    localparam int unsigned CLS_NZERO = 3;
    localparam int unsigned CLS_PZERO = 4;
    localparam int unsigned CLS_PSUB = 5;
    localparam int unsigned CLS_PNRM = 6;
    localparam int unsigned CLS_PINF = 7;
    localparam int unsigned CLS_SNAN = 8;
    localparam int unsigned CLS_QNAN = 9;

    localparam logic [CLS_W-1:0] NAN_MASK  = 10'b11_0000_0000;
    localparam logic [CLS_W-1:0] SNAN_MASK = 10'b01_0000_0000;
    localparam logic [CLS_W-1:0] ZERO_MASK = 10'b00_0001_1000;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    localparam int unsigned SIGN_BIT  = 31;
    localparam int unsigned EXP_MSB   = 30;
    localparam int unsigned EXP_LSB   = 23;
    localparam int unsigned MAN_MSB   = 22;
    localparam int unsigned QUIET_BIT = 22;

endpackage

// File: rtl/fp_class_mask.sv
// Combinational classifier: single-precision value to one-hot 10-bit
// class mask (FCLASS.S bit layout).
module fp_class_mask
    import fp_pkg::*;
(
    input  logic [31:0]      val,
    output logic [CLS_W-1:0] cls
);

    logic                       sign;
    logic [EXP_MSB-EXP_LSB:0]   expo;
    logic [MAN_MSB:0]           man;

    assign sign = val[SIGN_BIT];
    assign expo = val[EXP_MSB:EXP_LSB];
    assign man  = val[MAN_MSB:0];

    always_comb begin
        cls = '0;
        if (expo == '1) begin
            if (man == '0)
                cls[sign ? CLS_NINF : CLS_PINF] = 1'b1;
            else if (man[QUIET_BIT])
                cls[CLS_QNAN] = 1'b1;
            else
                cls[CLS_SNAN] = 1'b1;
        end else if (expo == '0) begin
            if (man == '0)
                cls[sign ? CLS_NZERO : CLS_PZERO] = 1'b1;
            else
                cls[sign ? CLS_NSUB : CLS_PSUB] = 1'b1;
        end else begin
            cls[sign ? CLS_NNRM : CLS_PNRM] = 1'b1;
        end
    end

endmodule

// File: rtl/fp_cmp_unit.sv
// Two-stage pipelined FEQ/FLT/FLE/FMIN/FMAX/FCLASS unit: stage 1 classifies
// both operands, stage 2 compares/selects and drives the output register.
module fp_cmp_unit
    import fp_pkg::*;
#(
    parameter int unsigned TAG_W     = 5,
    parameter logic [31:0] CANON_NAN = fp_pkg::CANON_NAN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [31:0]      rs1,
    input  logic [31:0]      rs2,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic [TAG_W-1:0] tag_out,
    output logic             flag_nv
);

    logic             s1_valid;
    logic [2:0]       s1_op;
    logic [TAG_W-1:0] s1_tag;
    logic [31:0]      s1_a;
    logic [31:0]      s1_b;
    logic [CLS_W-1:0] s1_cls1;
    logic [CLS_W-1:0] s1_cls2;
    logic [CLS_W-1:0] cls1_d;
    logic [CLS_W-1:0] cls2_d;

    logic s2_adv;
    logic s1_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    fp_class_mask u_cls1 (.val(rs1), .cls(cls1_d));
    fp_class_mask u_cls2 (.val(rs2), .cls(cls2_d));

    always_ff @(posedge clk) begin
        if (rst)
            s1_valid <= 1'b0;
        else if (s1_adv)
            s1_valid <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            s1_op   <= op;
            s1_tag  <= tag_in;
            s1_a    <= rs1;
            s1_b    <= rs2;
            s1_cls1 <= cls1_d;
            s1_cls2 <= cls2_d;
        end
    end

    logic        nan1, nan2, snan1, snan2, any_nan, both_zero;
    logic        eq, lt;
    logic [31:0] sel_min, sel_max;
    logic [31:0] res_d;
    logic        nv_d;

    assign nan1      = |(s1_cls1 & NAN_MASK);
    assign nan2      = |(s1_cls2 & NAN_MASK);
    assign snan1     = |(s1_cls1 & SNAN_MASK);
    assign snan2     = |(s1_cls2 & SNAN_MASK);
    assign any_nan   = nan1 || nan2;
    assign both_zero = (|(s1_cls1 & ZERO_MASK)) && (|(s1_cls2 & ZERO_MASK));
    assign eq        = !any_nan && (both_zero || (s1_a == s1_b));

    always_comb begin
        lt = 1'b0;
        if (s1_a[SIGN_BIT] != s1_b[SIGN_BIT])
            lt = s1_a[SIGN_BIT] && !both_zero;
        else if (!s1_a[SIGN_BIT])
            lt = s1_a[30:0] < s1_b[30:0];
        else
            lt = s1_a[30:0] > s1_b[30:0];
    end

    // Signed zeros compare equal, so the sign bit alone picks min/max there.
    always_comb begin
        sel_min = s1_b;
        sel_max = s1_a;
        if (nan1 && nan2) begin
            sel_min = CANON_NAN;
            sel_max = CANON_NAN;
        end else if (nan1) begin
            sel_min = s1_b;
            sel_max = s1_b;
        end else if (nan2) begin
            sel_min = s1_a;
            sel_max = s1_a;
        end else if (both_zero) begin
            sel_min = s1_a[SIGN_BIT] ? s1_a : s1_b;
            sel_max = s1_a[SIGN_BIT] ? s1_b : s1_a;
        end else begin
            sel_min = lt ? s1_a : s1_b;
            sel_max = lt ? s1_b : s1_a;
        end
    end

    always_comb begin
        res_d = '0;
        nv_d  = 1'b0;
        case (s1_op)
            OP_FEQ: begin
                res_d = {31'b0, eq};
                nv_d  = snan1 || snan2;
            end
            OP_FLT: begin
                res_d = {31'b0, lt && !any_nan};
                nv_d  = any_nan;
            end
            OP_FLE: begin
                res_d = {31'b0, (lt || eq) && !any_nan};
                nv_d  = any_nan;
            end
            OP_FMIN: begin
                res_d = sel_min;
                nv_d  = snan1 || snan2;
            end
            OP_FMAX: begin
                res_d = sel_max;
                nv_d  = snan1 || snan2;
            end
            OP_FCLASS: begin
                res_d = {22'b0, s1_cls1};
            end
            default: begin
                res_d = '0;
                nv_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            tag_out   <= '0;
            flag_nv   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result  <= res_d;
                tag_out <= s1_tag;
                flag_nv <= nv_d;
            end
        end
    end

endmodule
